clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Programmable processor-clock generator for the single-cycle MIPS core.
- Divides the board clock by a runtime-loadable ratio and supports three modes: run, stop and single-step (button-driven, one processor cycle per press).
- Provides a registered divided clock, a rising-edge tick pulse and a processor-cycle counter for the debug display.
- Sits between the board oscillator/buttons and the core clock input.

Parameters:
- CNT_W, 25, width of the half-period counter and of div_half.
- DEFAULT_HALF, 24999999, reset value of the active half-period (1 Hz out_clk from 50 MHz).
- CYC_W, 16, width of the processor-cycle counter.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous active-low reset.
- div_half  in  CNT_W  requested half-period minus 1, in clk cycles.
- load_div  in  1  when 1, div_half is captured into the pending register.
- mode  in  2  00 stop, 01 run, 10 step, 11 reserved (treated as stop).
- step_btn  in  1  asynchronous step request; synchronised internally.
- cyc_clr  in  1  synchronous clear of cyc_cnt.
- out_clk  out  1  registered divided clock.
- tick  out  1  one-clk pulse, high during the first clk cycle of each out_clk high phase.
- cyc_cnt  out  CYC_W  number of out_clk rising edges, wrapping.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Values on reset (rst=0):
  - out_clk=0, tick=0, cyc_cnt=0, cnt=0.
  - half_act = half_pend = DEFAULT_HALF.
  - Synchroniser flops cleared; state=IDLE.
  - Reset is immediate at any point, including mid-phase.
- Divide ratio:
  - load_div=1 captures div_half into half_pend on that edge.
  - half_act <= half_pend only at a phase boundary (cnt==half_act), or while in IDLE.
  - A phase in progress is never shortened or lengthened.
  - div_half=0 is legal: out_clk toggles every clk (divide by 2).
- Phase length: each phase lasts half_act+1 clk cycles; full period = 2*(half_act+1).
- Counter: at cnt==half_act, cnt<=0; otherwise cnt<=cnt+1. No other wrap path.
- States:
  - IDLE: out_clk=0, cnt=0.
    - mode=01 -> RUN; the first rise occurs half_act+1 cycles after entry.
    - mode=10 and a synced step_btn rising edge -> STEP_HI, with out_clk<=1 on the same edge.
  - RUN: free toggling at each phase boundary.
    - mode leaves 01 while out_clk=0 -> IDLE next edge; cnt<=0.
    - mode leaves 01 while out_clk=1 -> the high phase completes; at its boundary out_clk<=0 and state -> IDLE. No runt pulse.
  - STEP_HI: out_clk=1 for half_act+1 cycles, then out_clk<=0 -> STEP_LO.
  - STEP_LO: out_clk=0 for half_act+1 cycles (minimum low time), then -> IDLE.
    - Mode changes during STEP_HI/STEP_LO take effect only at IDLE.
- Step input:
  - step_btn passes through a 2-flop synchroniser followed by a rising-edge detect.
  - Edges arriving outside IDLE are discarded; they are not queued.
  - A held button produces exactly one step.
- tick:
  - Registered; tick=1 exactly on the clk cycle where out_clk has just become 1.
  - Therefore out_clk and tick rise on the same edge; tick falls one cycle later.
  - No tick is produced on falls.
- cyc_cnt:
  - Increments on every tick; wraps from all-ones to 0.
  - cyc_clr has priority over increment when both occur in the same cycle; the result is 0.

Decomposition:
- Package clk_div_pkg holds:
  - the mode encodings MODE_STOP/MODE_RUN/MODE_STEP;
  - the state enum IDLE/RUN/STEP_HI/STEP_LO;
  - the default constants.
- One sub-module: sync_edge, a 2-flop synchroniser plus rising-edge pulse with async active-low reset. It is reusable for the other board buttons.

Test Plan:
- Run timing: reset, load_div=1 with div_half=3, mode=01 -> first out_clk rise 4 cycles after entering RUN, period 8 clk; tick 1-cycle wide every 8; cyc_cnt=5 after 5 rises.
- Ratio change: while in RUN with half=3, load div_half=1 mid-high-phase -> current high phase still lasts 4 cycles; the subsequent phases last 2 cycles each.
- Stop cleanly: mode->00 two cycles into a high phase (half=3) -> out_clk stays high 2 more cycles, falls, stays 0; cnt=0, state IDLE; no further ticks.
- Single step: mode=10, half=2, step_btn held high 20 cycles -> exactly one 3-cycle high pulse and 3-cycle low; one tick; cyc_cnt +1. A second press during STEP_HI produces nothing.
- Reset mid-operation: assert rst during RUN high phase -> out_clk=0, tick=0, cyc_cnt=0 immediately, without a clk edge; after release, half_act=DEFAULT_HALF.
- Counter wrap and clear: force cyc_cnt to 0xFFFE, run 2 rises -> 0xFFFF then 0x0000; assert cyc_clr coincident with a tick -> 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared encodings and defaults for the processor-clock generator.
package clk_div_pkg;

   localparam logic [1:0] MODE_STOP = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STEP_HI,
      STEP_LO
   } state_t;

   localparam int DEF_CNT_W = 25;
   localparam int DEF_HALF  = 24999999;
   localparam int DEF_CYC_W = 16;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a one-clk rising-edge pulse.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   // Both terms come straight from flops, so the pulse is glitch-free.
   assign pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divided processor clock with run / stop / single-step modes,
// a rising-edge tick and a wrapping processor-cycle counter.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DEFAULT_HALF = DEF_HALF,
   parameter int CYC_W        = DEF_CYC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] div_half,
   input  logic             load_div,
   input  logic [1:0]       mode,
   input  logic             step_btn,
   input  logic             cyc_clr,
   output logic             out_clk,
   output logic             tick,
   output logic [CYC_W-1:0] cyc_cnt
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] half_act_reg;
   logic [CNT_W-1:0] half_pend_reg;
   logic [CYC_W-1:0] cyc_cnt_reg;
   logic             out_clk_reg;
   logic             tick_reg;
   logic             step_pulse;
   logic             phase_end;
   logic             run_sel;

   sync_edge u_step_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (step_btn),
      .pulse(step_pulse)
   );

   assign phase_end = (cnt_reg == half_act_reg);
   assign run_sel   = (mode == MODE_RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         half_act_reg  <= HALF_RST;
         half_pend_reg <= HALF_RST;
         cyc_cnt_reg   <= '0;
         out_clk_reg   <= 1'b0;
         tick_reg      <= 1'b0;
      end else begin
         tick_reg <= 1'b0;

         if (load_div)
            half_pend_reg <= div_half;
         // A new ratio only lands between phases so no phase is ever cut or stretched.
         if (phase_end || state_reg == IDLE)
            half_act_reg <= half_pend_reg;

         if (cyc_clr)
            cyc_cnt_reg <= '0;
         else if (tick_reg)
            cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);

         cnt_reg <= phase_end ? '0 : cnt_reg + CNT_W'(1);

         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (run_sel) begin
                  state_reg <= RUN;
               end else if (mode == MODE_STEP && step_pulse) begin
                  state_reg   <= STEP_HI;
                  out_clk_reg <= 1'b1;
                  tick_reg    <= 1'b1;
               end
            end
            RUN: begin
               if (!out_clk_reg && !run_sel) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else if (phase_end) begin
                  out_clk_reg <= ~out_clk_reg;
                  tick_reg    <= ~out_clk_reg;
                  // Stopping while high: let the high phase finish, then park low.
                  if (out_clk_reg && !run_sel)
                     state_reg <= IDLE;
               end
            end
            STEP_HI: begin
               if (phase_end) begin
                  out_clk_reg <= 1'b0;
                  state_reg   <= STEP_LO;
               end
            end
            STEP_LO: begin
               if (phase_end)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_clk = out_clk_reg;
   assign tick    = tick_reg;
   assign cyc_cnt = cyc_cnt_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: table-driven run ratios, hand-written corner sequences,
// and a phase-length scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_clk_div_ctrl;
   import clk_div_pkg::*;

   localparam int CNT_W = 25;
   localparam int DEF_H = 5;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic [CNT_W-1:0] div_half = '0;
   logic             load_div = 1'b0;
   logic [1:0]       mode     = MODE_STOP;
   logic             step_btn = 1'b0;
   logic             cyc_clr  = 1'b0;
   logic             out_clk;
   logic             tick;
   logic [15:0]      cyc_cnt;
   logic             out_clk_w;
   logic             tick_w;
   logic [3:0]       cyc_cnt_w;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int level;
      int len;
   } phase_t;

   typedef struct {
      logic [1:0] mode;
      int         half;
      int         periods;
      int         exp_lat;
      int         exp_len;
      int         exp_rises;
   } vec_t;

   phase_t exp_q[$];
   vec_t   vecs[6];
   int     rise_cnt = 0;
   logic   prev_out = 1'b0;
   logic   prev_w   = 1'b0;
   int     run_len  = 0;

   clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_H), .CYC_W(16)) dut (
      .clk(clk), .rst(rst), .div_half(div_half), .load_div(load_div), .mode(mode),
      .step_btn(step_btn), .cyc_clr(cyc_clr), .out_clk(out_clk), .tick(tick), .cyc_cnt(cyc_cnt)
   );

   // Narrow counter copy so the wrap boundary is reachable in a short run.
   clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_H), .CYC_W(4)) dut_w (
      .clk(clk), .rst(rst), .div_half(div_half), .load_div(load_div), .mode(mode),
      .step_btn(step_btn), .cyc_clr(cyc_clr), .out_clk(out_clk_w), .tick(tick_w), .cyc_cnt(cyc_cnt_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) step_clk();
   endtask

   task automatic load_half(input int h);
      div_half = CNT_W'(h);
      load_div = 1'b1;
      step_clk();
      load_div = 1'b0;
   endtask

   task automatic push_phase(input int level, input int len);
      phase_t ph;
      ph.level = level;
      ph.len   = len;
      exp_q.push_back(ph);
   endtask

   // Counts edges from the mode change until out_clk is high, then steps once more
   // so the monitor has consumed the rise before new phases are queued.
   task automatic wait_rise(input string name, input int exp_lat);
      int n = 0;
      while (out_clk !== 1'b1 && n < 100) begin
         step_clk();
         n++;
      end
      check(name, n, exp_lat);
      step_clk();
   endtask

   task automatic wait_rise_within(input string name, input int max_lat);
      int n = 0;
      while (out_clk !== 1'b1 && n < 100) begin
         step_clk();
         n++;
      end
      check(name, (n <= max_lat) ? 1 : 0, 1);
      step_clk();
   endtask

   task automatic wait_rises(input string name, input int n_rises);
      int r0 = rise_cnt;
      int n  = 0;
      while (rise_cnt - r0 < n_rises && n < 100) begin
         step_clk();
         n++;
      end
      check(name, rise_cnt - r0, n_rises);
   endtask

   task automatic wait_sb_empty(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step_clk();
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: tick must mark exactly the first high cycle; completed phases are scored.
   initial begin
      phase_t ph;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("tick", tick, (out_clk && !prev_out));
            check("tick_w", tick_w, (out_clk_w && !prev_w));
         end
         if (out_clk !== prev_out) begin
            if (exp_q.size() > 0) begin
               ph = exp_q.pop_front();
               check("phase_level", prev_out, ph.level);
               check("phase_len", run_len, ph.len);
            end
            if (out_clk) rise_cnt++;
            run_len = 1;
         end else begin
            run_len++;
         end
         prev_out = out_clk;
         prev_w   = out_clk_w;
      end
   end

   initial begin
      logic [15:0] c0;
      int          r0;
      int          n;

      vecs[0] = '{MODE_RUN, 3, 3, 5, 4, 4};
      vecs[1] = '{MODE_RUN, 0, 4, 2, 1, 5};
      vecs[2] = '{MODE_RUN, 1, 3, 3, 2, 4};
      vecs[3] = '{MODE_RUN, 6, 2, 8, 7, 3};
      vecs[4] = '{2'b11,    2, 0, 0, 3, 0};
      vecs[5] = '{MODE_STEP, 2, 0, 0, 3, 0};

      #2 rst = 1'b0;
      cycles(3);
      check("rst_out_clk", out_clk, 0);
      check("rst_tick", tick, 0);
      check("rst_cyc_cnt", cyc_cnt, 0);
      rst = 1'b1;
      cycles(2);

      // Reset ratio: first rise DEFAULT_HALF+1 cycles after entering RUN.
      mode = MODE_RUN;
      wait_rise("default_lat", DEF_H + 2);
      mode = MODE_STOP;
      cycles(20);

      foreach (vecs[v]) begin
         load_half(vecs[v].half);
         c0 = cyc_cnt;
         r0 = rise_cnt;
         mode = vecs[v].mode;
         if (vecs[v].exp_rises == 0) begin
            cycles(3 * vecs[v].exp_len + 4);
         end else begin
            wait_rise("run_lat", vecs[v].exp_lat);
            for (int p = 0; p < vecs[v].periods; p++) begin
               push_phase(1, vecs[v].exp_len);
               push_phase(0, vecs[v].exp_len);
            end
            wait_sb_empty("run_phases");
         end
         mode = MODE_STOP;
         cycles(20);
         check("run_rises", rise_cnt - r0, vecs[v].exp_rises);
         check("run_cyc", 16'(cyc_cnt - c0), vecs[v].exp_rises);
         check("run_idle_out", out_clk, 0);
         $display("vector %0d mode=%0d half=%0d rises=%0d", v, vecs[v].mode, vecs[v].half, rise_cnt - r0);
      end

      // Ratio change in mid-high phase: current high keeps 4 cycles, then 2-cycle phases.
      load_half(3);
      mode = MODE_RUN;
      wait_rise("ratio_lat", 5);
      push_phase(1, 4);
      push_phase(0, 2);
      push_phase(1, 2);
      push_phase(0, 2);
      load_half(1);
      wait_sb_empty("ratio_phases");
      mode = MODE_STOP;
      cycles(20);
      $display("ratio change sequence done");

      // Stop two cycles into a high phase: no runt pulse, then parked low.
      load_half(3);
      c0 = cyc_cnt;
      r0 = rise_cnt;
      mode = MODE_RUN;
      wait_rise("stop_lat", 5);
      push_phase(1, 4);
      step_clk();
      mode = MODE_STOP;
      step_clk();
      check("stop_hold", out_clk, 1);
      step_clk();
      check("stop_fall", out_clk, 0);
      wait_sb_empty("stop_phase");
      cycles(20);
      check("stop_out", out_clk, 0);
      check("stop_rises", rise_cnt - r0, 1);
      check("stop_cyc", 16'(cyc_cnt - c0), 1);

      // Restart from IDLE and a stop during a low phase both restart the count from 0.
      mode = MODE_RUN;
      wait_rise("restart_lat", 5);
      cycles(3);
      check("low_entry", out_clk, 0);
      step_clk();
      mode = MODE_STOP;
      step_clk();
      mode = MODE_RUN;
      wait_rise("low_stop_lat", 5);
      mode = MODE_STOP;
      cycles(20);
      $display("stop sequences done");

      // Single step with a held button: exactly one 3-cycle pulse.
      load_half(2);
      mode = MODE_STEP;
      cycles(2);
      c0 = cyc_cnt;
      r0 = rise_cnt;
      step_btn = 1'b1;
      wait_rise_within("step_seen", 6);
      push_phase(1, 3);
      cycles(18);
      wait_sb_empty("step_phase");
      check("step_rises", rise_cnt - r0, 1);
      check("step_cyc", 16'(cyc_cnt - c0), 1);
      step_btn = 1'b0;
      cycles(5);
      check("step_low", out_clk, 0);

      // Second press, re-pressed during the pulse: the extra edge is dropped.
      c0 = cyc_cnt;
      r0 = rise_cnt;
      step_btn = 1'b1;
      wait_rise_within("step2_seen", 6);
      push_phase(1, 3);
      step_btn = 1'b0;
      step_clk();
      step_btn = 1'b1;
      cycles(20);
      wait_sb_empty("step2_phase");
      check("step2_rises", rise_cnt - r0, 1);
      check("step2_cyc", 16'(cyc_cnt - c0), 1);
      step_btn = 1'b0;
      mode = MODE_STOP;
      cycles(5);
      $display("single step sequences done");

      // Asynchronous reset while high, in the tick cycle.
      load_half(3);
      mode = MODE_RUN;
      n = 0;
      while (out_clk !== 1'b1 && n < 100) begin
         step_clk();
         n++;
      end
      check("rst_pre_out", out_clk, 1);
      check("rst_pre_tick", tick, 1);
      rst = 1'b0;
      #2;
      check("rst_mid_out", out_clk, 0);
      check("rst_mid_tick", tick, 0);
      check("rst_mid_cyc", cyc_cnt, 0);
      check("rst_mid_cyc_w", cyc_cnt_w, 0);
      mode = MODE_STOP;
      step_clk();
      rst = 1'b1;
      step_clk();
      mode = MODE_RUN;
      wait_rise("rst_default_lat", DEF_H + 2);
      mode = MODE_STOP;
      cycles(20);
      cyc_clr = 1'b1;
      step_clk();
      cyc_clr = 1'b0;
      check("clr_idle", cyc_cnt, 0);
      check("clr_idle_w", cyc_cnt_w, 0);
      $display("reset sequence done");

      // Counter wrap on the 4-bit copy, then clear coincident with a tick.
      load_half(0);
      mode = MODE_RUN;
      wait_rises("wrap_rises14", 14);
      check("wrap_e", cyc_cnt_w, 14);
      wait_rises("wrap_rises15", 1);
      check("wrap_f", cyc_cnt_w, 15);
      wait_rises("wrap_rises16", 1);
      check("wrap_0", cyc_cnt_w, 0);
      check("wrap_wide", cyc_cnt, 16);
      n = 0;
      while (tick !== 1'b1 && n < 10) begin
         step_clk();
         n++;
      end
      check("clr_tick_seen", tick, 1);
      cyc_clr = 1'b1;
      step_clk();
      cyc_clr = 1'b0;
      check("clr_prio", cyc_cnt, 0);
      check("clr_prio_w", cyc_cnt_w, 0);
      mode = MODE_STOP;
      cycles(10);
      $display("wrap and clear sequence done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
